serial_tx: RTL
==============

SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter WIDTH, default 8, number of data bits per transfer (>=2).
REQ-002 Parameter DIV, default 4, Clk cycles per serial bit period (even, >=2).
REQ-003 Clk  input  1  system clock; all state changes on rising edge.
REQ-004 Resetn  input  1  reset, asynchronous, active-low.
REQ-005 Load  input  1  request to start a transfer; sampled only while Ready=1.
REQ-006 DataIn  input  WIDTH  parallel word captured on accepted Load.
REQ-007 Ready  output  1  high when idle and able to accept Load.
REQ-008 SerOut  output  1  serial data, MSB first, registered.
REQ-009 SerClk  output  1  bit strobe for a downstream edge-triggered capture flip-flop; rising edge mid-bit.
REQ-010 Done  output  1  single-cycle pulse after the last bit period.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-012 IDLE SHALL drive Ready=1, SerClk=0, Done=0, SerOut=0.
REQ-013 Load=1 at a rising edge in IDLE SHALL load DataIn into the WIDTH-bit shift register, set bit counter to WIDTH-1 and divider counter to 0, and enter SHIFT.
REQ-014 Load=0 in IDLE SHALL leave state unchanged.
REQ-015 SerOut SHALL equal the shift register MSB at all times.
REQ-016 In SHIFT the divider counter SHALL count 0..DIV-1 and wrap to 0.
REQ-017 SerClk SHALL be 0 while divider < DIV/2 and 1 while divider >= DIV/2, only in SHIFT.
REQ-018 On divider wrap with bit counter != 0: shift register shifts left one place (0 into LSB), bit counter decrements.
REQ-019 On divider wrap with bit counter = 0: shift register cleared to 0, enter DONE.
REQ-020 DONE SHALL last exactly one cycle with Done=1, Ready=0, SerClk=0, then enter IDLE.
REQ-021 Ready SHALL be 0 in SHIFT and DONE; Load in those states SHALL be ignored and DataIn changes SHALL not affect the transfer in progress.
REQ-022 Latency: the accepted Load edge is edge 0; Done SHALL be high in the cycle after edge WIDTH*DIV, and Ready high again after edge WIDTH*DIV+1.
REQ-023 Load held high continuously SHALL start the next transfer at the first IDLE edge, giving exactly one IDLE cycle between transfers.
REQ-024 Each data bit SHALL be stable on SerOut for DIV cycles and for at least DIV/2 cycles before and after its SerClk rising edge.

Reset
REQ-025 Resetn=0 SHALL immediately, without Clk, force IDLE, shift register=0, counters=0, Ready=1, SerOut=0, SerClk=0, Done=0.
REQ-026 Reset asserted mid-transfer SHALL abort it with no Done pulse; the first Load after release SHALL start a fresh full transfer.
REQ-027 Reset release SHALL be sampled on Clk; Load at the first edge after release SHALL be accepted.

Verification
REQ-028 Power-up: Resetn=0, no Clk -> Ready=1, SerOut=0, SerClk=0, Done=0.
REQ-029 WIDTH=8, DIV=4, DataIn=8'hA5, one-cycle Load -> SerOut 1,0,1,0,0,1,0,1, 4 cycles each; SerClk high in cycles 2-3 of each bit; Done single pulse after edge 32; Ready=1 after edge 33.
REQ-030 Load pulsed and DataIn changed to 8'h3C during SHIFT -> output stream still 8'hA5, Ready stays 0, exactly one Done.
REQ-031 Load held high, DataIn=8'hFF then 8'h00 -> two back-to-back transfers, one IDLE cycle between, SerOut all 1s then all 0s.
REQ-032 Resetn pulsed low at cycle 13 of an 8'hA5 transfer -> outputs reset asynchronously, no Done; next Load of 8'h81 -> 1,0,0,0,0,0,0,1.
REQ-033 Loopback: SerOut into an 8-stage shift register of master-slave flip-flops clocked by SerClk -> captured word equals DataIn for 8'hA5, 8'h5A, 8'h00, 8'hFF.

Source files
------------

// File: rtl/serial_tx.sv
// MSB-first parallel-to-serial transmitter with divided bit strobe.
// One transfer per accepted Load; Done pulses once after the last bit period.
module serial_tx #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 4
) (
    input  logic             Clk,
    input  logic             Resetn,
    input  logic             Load,
    input  logic [WIDTH-1:0] DataIn,
    output logic             Ready,
    output logic             SerOut,
    output logic             SerClk,
    output logic             Done
);

    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(DIV / 2);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic [BW-1:0]    bitcnt, bitcnt_nx;
    logic [DW-1:0]    divcnt, divcnt_nx;
    logic             serclk_q, serclk_nx;

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state    <= IDLE;
            shreg    <= '0;
            bitcnt   <= '0;
            divcnt   <= '0;
            serclk_q <= 1'b0;
        end else begin
            state    <= state_nx;
            shreg    <= shreg_nx;
            bitcnt   <= bitcnt_nx;
            divcnt   <= divcnt_nx;
            serclk_q <= serclk_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        shreg_nx  = shreg;
        bitcnt_nx = bitcnt;
        divcnt_nx = divcnt;
        case (state)
            IDLE: begin
                if (Load) begin
                    shreg_nx  = DataIn;
                    bitcnt_nx = BIT_LAST;
                    divcnt_nx = '0;
                    state_nx  = SHIFT;
                end
            end
            SHIFT: begin
                if (divcnt == DIV_LAST) begin
                    divcnt_nx = '0;
                    if (bitcnt == '0) begin
                        shreg_nx = '0;
                        state_nx = DONE;
                    end else begin
                        shreg_nx  = {shreg[WIDTH-2:0], 1'b0};
                        bitcnt_nx = bitcnt - BW'(1);
                    end
                end else begin
                    divcnt_nx = divcnt + DW'(1);
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        // Strobe is registered from next-state values so it stays glitch-free
        // while still tracking the divider phase of the current cycle.
        serclk_nx = (state_nx == SHIFT) && (divcnt_nx >= DIV_HALF);
    end

    always_comb begin
        Ready  = (state == IDLE);
        Done   = (state == DONE);
        SerOut = shreg[WIDTH-1];
        SerClk = serclk_q;
    end

endmodule
